// File: rtl/data_mem_responder_if.sv
// ============================================================================
// Module : data_mem_responder_if
// Brief  : MEM-stage data memory request/response bus with a debug read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface data_mem_responder_if #(
  parameter int len     = 32,
  parameter int NB_ADDR = 11
);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [len-1:0]     req_addr;
  logic [len-1:0]     req_wdata;
  logic [1:0]         req_size;
  logic               req_unsigned;
  logic               rsp_valid;
  logic [len-1:0]     rsp_rdata;
  logic               rsp_error;
  logic [NB_ADDR-1:0] dbg_addr;
  logic [len-1:0]     dbg_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, dbg_addr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, dbg_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, dbg_addr,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, dbg_data
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module : data_mem_responder
// Brief  : Data RAM responder: one request at a time, subword RMW stores,
//          sign/zero-extended subword loads, combinational debug read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder #(
  parameter int len       = 32,
  parameter int RAM_DEPTH = 2048,
  parameter int NB_ADDR   = $clog2(RAM_DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  data_mem_responder_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [len-1:0]       r_mem [RAM_DEPTH] = '{default: '0};

  logic [NB_ADDR-1:0]   r_idx;
  logic [1:0]           r_lane;
  logic [len-1:0]       r_wdata;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic                 r_write;
  logic                 r_err;
  logic [len-1:0]       r_word;

  logic                 w_accept;
  logic                 w_err;
  logic [len-1:0]       w_merged;
  logic [len-1:0]       w_load;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic                 w_unused_addr;

  assign w_unused_addr = ^bus.req_addr[len-1:NB_ADDR+2];

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_err    = (bus.req_size == 2'b11) ||
                    ((bus.req_size == c_SZ_HALF) && bus.req_addr[0]) ||
                    ((bus.req_size == c_SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_err)
            w_state_nxt = S_RSP;
          else if (bus.req_write && (bus.req_size == c_SZ_WORD))
            w_state_nxt = S_WR;
          else
            w_state_nxt = S_RD;
        end
      end
      S_RD:    w_state_nxt = r_write ? S_WR : S_RSP;
      S_WR:    w_state_nxt = S_RSP;
      S_RSP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_lane     <= '0;
      r_wdata    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      r_word     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_idx      <= bus.req_addr[NB_ADDR+1:2];
        r_lane     <= bus.req_addr[1:0];
        r_wdata    <= bus.req_wdata;
        r_size     <= bus.req_size;
        r_unsigned <= bus.req_unsigned;
        r_write    <= bus.req_write;
        r_err      <= w_err;
      end
      if (r_state == S_RD)
        r_word <= r_mem[r_idx];
    end
  end

  // Write enable comes from the reset state register, so an async reset in WR drops the write.
  always_ff @(posedge clk) begin
    if (r_state == S_WR)
      r_mem[r_idx] <= w_merged;
  end

  always_comb begin
    w_merged = r_word;
    case (r_size)
      c_SZ_BYTE: w_merged[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
      c_SZ_HALF: w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
      default:   w_merged = r_wdata;
    endcase
  end

  assign w_byte = r_word[{r_lane, 3'b000} +: 8];
  assign w_half = r_word[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = r_word;
    case (r_size)
      c_SZ_BYTE: w_load = {{(len-8){~r_unsigned & w_byte[7]}}, w_byte};
      c_SZ_HALF: w_load = {{(len-16){~r_unsigned & w_half[15]}}, w_half};
      default:   w_load = r_word;
    endcase
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RSP);
  assign bus.rsp_error = (r_state == S_RSP) && r_err;
  assign bus.rsp_rdata = ((r_state == S_RSP) && !r_err && !r_write) ? w_load : '0;
  assign bus.dbg_data  = r_mem[bus.dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module : tb_data_mem_responder
// Brief  : Directed table-driven bench for data_mem_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_mem_responder_if #(.len(32), .NB_ADDR(11)) bus ();

  data_mem_responder #(.len(32), .RAM_DEPTH(2048)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [10:0] dbg_idx;
    logic [31:0] exp_dbg;
  } vec_t;

  localparam int c_NVEC = 21;
  vec_t vecs [c_NVEC];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_size     = v.sz;
    bus.req_unsigned = v.uns;
    bus.dbg_addr     = v.dbg_idx;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int  lat;
    bit  seen;
    @(negedge clk);
    check({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    drive_req(v);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 6 && !seen; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: rsp_valid not seen in 6 cycles, expected latency %0d", tag, v.exp_lat);
    end else begin
      check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
      check({tag, " rdata"}, bus.rsp_rdata, v.exp_rdata);
      check({tag, " error"}, 32'(bus.rsp_error), 32'(v.exp_err));
      check({tag, " dbg"}, bus.dbg_data, v.exp_dbg);
      @(negedge clk);
      check({tag, " pulse"}, 32'(bus.rsp_valid), 32'd0);
    end
  endtask

  initial begin
    vec_t v;
    bit   saw_rsp;

    //          wr    addr        wdata          sz     uns   exp_rdata      err   lat dbg     exp_dbg
    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0, 2, 11'd4, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 2, 11'd4, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h11,   32'h123456AA, 2'b00, 1'b0, 32'h0,        1'b0, 3, 11'd4, 32'hDEADAAEF};
    vecs[3]  = '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'hDEADAAEF, 1'b0, 2, 11'd4, 32'hDEADAAEF};
    vecs[4]  = '{1'b0, 32'h11,   32'h0,        2'b00, 1'b0, 32'hFFFFFFAA, 1'b0, 2, 11'd4, 32'hDEADAAEF};
    vecs[5]  = '{1'b0, 32'h11,   32'h0,        2'b00, 1'b1, 32'h000000AA, 1'b0, 2, 11'd4, 32'hDEADAAEF};
    vecs[6]  = '{1'b1, 32'h12,   32'h00001234, 2'b01, 1'b0, 32'h0,        1'b0, 3, 11'd4, 32'h1234AAEF};
    vecs[7]  = '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'h1234AAEF, 1'b0, 2, 11'd4, 32'h1234AAEF};
    vecs[8]  = '{1'b0, 32'h12,   32'h0,        2'b01, 1'b0, 32'h00001234, 1'b0, 2, 11'd4, 32'h1234AAEF};
    vecs[9]  = '{1'b0, 32'h10,   32'h0,        2'b01, 1'b0, 32'hFFFFAAEF, 1'b0, 2, 11'd4, 32'h1234AAEF};
    vecs[10] = '{1'b0, 32'h10,   32'h0,        2'b01, 1'b1, 32'h0000AAEF, 1'b0, 2, 11'd4, 32'h1234AAEF};
    vecs[11] = '{1'b0, 32'h13,   32'h0,        2'b01, 1'b0, 32'h0,        1'b1, 1, 11'd5, 32'h0};
    vecs[12] = '{1'b1, 32'h16,   32'hFFFFFFFF, 2'b10, 1'b0, 32'h0,        1'b1, 1, 11'd5, 32'h0};
    vecs[13] = '{1'b1, 32'h14,   32'hFFFFFFFF, 2'b11, 1'b0, 32'h0,        1'b1, 1, 11'd5, 32'h0};
    vecs[14] = '{1'b1, 32'h2010, 32'h00000055, 2'b10, 1'b0, 32'h0,        1'b0, 2, 11'd4, 32'h00000055};
    vecs[15] = '{1'b0, 32'h10,   32'h0,        2'b10, 1'b0, 32'h00000055, 1'b0, 2, 11'd4, 32'h00000055};
    vecs[16] = '{1'b0, 32'h13,   32'h0,        2'b00, 1'b0, 32'h0,        1'b0, 2, 11'd4, 32'h00000055};
    vecs[17] = '{1'b0, 32'h10,   32'h0,        2'b00, 1'b1, 32'h00000055, 1'b0, 2, 11'd4, 32'h00000055};
    vecs[18] = '{1'b1, 32'h17,   32'hFFFFFF80, 2'b00, 1'b0, 32'h0,        1'b0, 3, 11'd5, 32'h80000000};
    vecs[19] = '{1'b0, 32'h17,   32'h0,        2'b00, 1'b0, 32'hFFFFFF80, 1'b0, 2, 11'd5, 32'h80000000};
    vecs[20] = '{1'b0, 32'h16,   32'h0,        2'b01, 1'b0, 32'hFFFF8000, 1'b0, 2, 11'd5, 32'h80000000};

    reset            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.dbg_addr     = 11'd4;

    #12;
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset rsp_error", 32'(bus.rsp_error), 32'd0);
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset ram zero", bus.dbg_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < c_NVEC; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // SB abandoned by reset while in WR: word 4 must keep 0x55
    v = '{1'b1, 32'h10, 32'h00000077, 2'b00, 1'b0, 32'h0, 1'b0, 3, 11'd4, 32'h00000055};
    @(negedge clk);
    drive_req(v);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstwr ready in RD", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstwr rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rstwr rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rstwr rsp_error", 32'(bus.rsp_error), 32'd0);
    check("rstwr ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    saw_rsp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) saw_rsp = 1'b1;
    end
    check("rstwr no response", 32'(saw_rsp), 32'd0);
    check("rstwr ready after", 32'(bus.req_ready), 32'd1);
    check("rstwr dbg word", bus.dbg_data, 32'h00000055);
    v = '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h00000055, 1'b0, 2, 11'd4, 32'h00000055};
    run_vec(v, "rstwr reload");

    // Two loads with req_valid held high: accepts at T and T+3
    @(negedge clk);
    drive_req(v);
    check("b2b ready0", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b2b ready T+1", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("b2b ready T+2", 32'(bus.req_ready), 32'd0);
    check("b2b rsp1 valid", 32'(bus.rsp_valid), 32'd1);
    check("b2b rsp1 data", bus.rsp_rdata, 32'h00000055);
    @(negedge clk);
    check("b2b ready T+3", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b ready T+4", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("b2b rsp2 valid", 32'(bus.rsp_valid), 32'd1);
    check("b2b rsp2 data", bus.rsp_rdata, 32'h00000055);
    @(negedge clk);
    check("b2b idle", 32'(bus.req_ready), 32'd1);
    check("b2b rsp2 pulse", 32'(bus.rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
